// File: rtl/main_memory_wb.sv
// main_memory_wb: block-organised main memory for a write-back cache.
// 64 blocks of 128 bits (four 32-bit words), combinational block read and
// single-edge block write. Asynchronous reset loads word k with the value k.
// Optional feature macro: MAIN_MEM_WB_BYPASS_EN. When it is defined, a block
// being written is forwarded from WT onto RD before the clock edge.
module main_memory_wb #(
  parameter int ADDR_W = 10,
  parameter int BLK_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [BLK_W-1:0]  WT,
  input  logic              write,
  output logic [BLK_W-1:0]  RD
);

  localparam int OFS_W  = 4;
  localparam int IDX_W  = ADDR_W - OFS_W;
  localparam int NBLK   = 1 << IDX_W;
  localparam int WORD_W = 32;
  localparam int WORDS  = BLK_W / WORD_W;

  // Reset image of one block: word offset 0 sits in the top bits, and the
  // word at global position k holds the value k.
  function automatic logic [BLK_W-1:0] f_reset_block(input int unsigned blk);
    logic [BLK_W-1:0] v;
    v = '0;
    for (int unsigned o = 0; o < WORDS; o++) begin
      v[BLK_W-1-WORD_W*o -: WORD_W] = WORD_W'(blk * WORDS + o);
    end
    return v;
  endfunction

  logic [BLK_W-1:0] r_mem [NBLK];
  logic [IDX_W-1:0] w_idx;
  logic             w_unused_ofs;

  // Only the block index selects storage; the byte offset is dropped.
  assign w_idx        = Address[ADDR_W-1:OFS_W];
  assign w_unused_ofs = ^Address[OFS_W-1:0];

  // Storage: async reset reloads the whole image and wins over any write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NBLK; b++) begin
        r_mem[b] <= f_reset_block(b);
      end
    end else if (write) begin
      r_mem[w_idx] <= WT;
    end
  end

  // Combinational block read, optionally forwarding the in-flight write.
  always_comb begin
    RD = r_mem[w_idx];
`ifdef MAIN_MEM_WB_BYPASS_EN
    // Read and write share one address, so a write always targets the
    // block being read; reset suppresses the forward so RD shows reset data.
    if (write && !reset) begin
      RD = WT;
    end
`endif
  end

endmodule

// File: tb/tb_main_memory_wb.sv
// Self-checking bench for main_memory_wb: table of directed vectors plus
// hand-written sequences for reset timing and the write-forward behaviour.
module tb_main_memory_wb;

  logic         clk;
  logic         reset;
  logic [9:0]   Address;
  logic [127:0] WT;
  logic         write;
  logic [127:0] RD;

  int n_tests;
  int n_fail;

  main_memory_wb #(.ADDR_W(10), .BLK_W(128)) dut (
    .clk     (clk),
    .reset   (reset),
    .Address (Address),
    .WT      (WT),
    .write   (write),
    .RD      (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [9:0]   addr;
    logic [127:0] wt;
    logic         wr;
    int           edges;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: RD=%h expected %h", name, got, exp);
    end
  endtask

  localparam logic [127:0] BLK0  = 128'h00000000_00000001_00000002_00000003;
  localparam logic [127:0] BLK63 = 128'h000000FC_000000FD_000000FE_000000FF;
  localparam logic [127:0] DEAD  = 128'hDEADBEEF_11111111_22222222_33333333;
  localparam logic [127:0] PAT1  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] PAT2  = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
  localparam logic [127:0] FIVES = 128'h55555555_55555555_55555555_55555555;
  localparam logic [127:0] AAAS  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;

  initial begin
    logic [127:0] exp_byp;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{"rd_blk0",        10'h000, '0,     1'b0, 0, BLK0};
    vecs[1]  = '{"rd_3f4",         10'h3F4, '0,     1'b0, 0, BLK63};
    vecs[2]  = '{"rd_00f_offset",  10'h00F, '0,     1'b0, 0, BLK0};
    vecs[3]  = '{"wr_125",         10'h125, DEAD,   1'b1, 1, DEAD};
    vecs[4]  = '{"rd_120",         10'h120, '0,     1'b0, 0, DEAD};
    vecs[5]  = '{"rd_130",         10'h130, '0,     1'b0, 0, 128'h0000004C_0000004D_0000004E_0000004F};
    vecs[6]  = '{"rd_11c",         10'h11C, '0,     1'b0, 0, 128'h00000044_00000045_00000046_00000047};
    vecs[7]  = '{"nowr_040_3edge", 10'h040, '1,     1'b0, 3, 128'h00000010_00000011_00000012_00000013};
    vecs[8]  = '{"wr_3f0",         10'h3F0, PAT1,   1'b1, 1, PAT1};
    vecs[9]  = '{"rd_3ec",         10'h3EC, '0,     1'b0, 0, 128'h000000F8_000000F9_000000FA_000000FB};
    vecs[10] = '{"rd_blk0_again",  10'h000, '0,     1'b0, 0, BLK0};
    vecs[11] = '{"wr_00a",         10'h00A, PAT2,   1'b1, 1, PAT2};
    vecs[12] = '{"rd_3ff",         10'h3FF, '0,     1'b0, 0, PAT1};
    vecs[13] = '{"wr_050",         10'h050, FIVES,  1'b1, 1, FIVES};

    // Reset: rising edge of reset loads the image without any clock edge.
    reset   = 1'b0;
    write   = 1'b0;
    Address = 10'h000;
    WT      = '0;
    #1 reset = 1'b1;
    #1 check("reset_blk0", RD, BLK0);

    // Writes are ignored while reset is held across a clock edge.
    @(negedge clk);
    write   = 1'b1;
    WT      = '1;
    Address = 10'h000;
    @(posedge clk);
    #1 check("wr_during_reset", RD, BLK0);
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < $size(vecs); i++) begin
      @(negedge clk);
      Address = vecs[i].addr;
      WT      = vecs[i].wt;
      write   = vecs[i].wr;
      for (int e = 0; e < vecs[i].edges; e++) @(posedge clk);
      #1 check(vecs[i].name, RD, vecs[i].exp);
    end

    // Forwarding check before and after the write edge at 0x200.
    @(negedge clk);
    Address = 10'h200;
    WT      = AAAS;
    write   = 1'b1;
`ifdef MAIN_MEM_WB_BYPASS_EN
    exp_byp = AAAS;
`else
    exp_byp = 128'h00000080_00000081_00000082_00000083;
`endif
    #1 check("pre_edge_200", RD, exp_byp);
    @(posedge clk);
    #1 check("post_edge_200", RD, AAAS);
    @(negedge clk);
    write = 1'b0;

    // Reset asserted between edges after writing block 5 takes effect at once.
    Address = 10'h050;
    #1 check("blk5_before_reset", RD, FIVES);
    #1 reset = 1'b1;
    #1 check("async_reset_blk5", RD, 128'h00000014_00000015_00000016_00000017);
    Address = 10'h120;
    #1 check("reset_clears_125", RD, 128'h00000048_00000049_0000004A_0000004B);
    Address = 10'h3F4;
    #1 check("reset_clears_3f0", RD, BLK63);
    @(negedge clk);
    reset = 1'b0;

    // Reset rising on the same edge as a pending write overrides it.
    Address = 10'h060;
    WT      = DEAD;
    write   = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    #1 check("reset_beats_write", RD, 128'h00000018_00000019_0000001A_0000001B);
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1 check("blk6_after_release", RD, 128'h00000018_00000019_0000001A_0000001B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
